cp0_unit: RTL and testbench

Coprocessor-0 register file and exception/interrupt arbiter for the pipelined MIPS core. It sits beside the memory stage and responds to the MFC0, MTC0, ERET and ExcCode signals that the instruction decoder produces. It holds SR, Cause, EPC and PRId. Each cycle it decides whether the instruction now in M is interrupted or excepted, and it supplies the handler-return address used by ERET.

---
 rtl/cp0_unit.sv | 119 +++++++++++
 tb/tb_cp0_unit.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// Coprocessor-0 register file (SR, Cause, EPC, PRId) with the exception/interrupt
// arbiter for the M stage of the pipelined MIPS core.
module cp0_unit #(
    parameter logic [31:0] PRID_VALUE = 32'h1900_0808
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        We,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcCodeIn,
    input  logic        EXLClr,
    input  logic [5:0]  HWInt,
    output logic        IntReq,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;

    logic        int_pend;
    logic        exc_pend;
    logic [31:0] pc_aligned;
    logic [31:0] epc_exc;
    logic [31:0] sr_word;
    logic [31:0] cause_word;

    assign int_pend   = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_pend   = (ExcCodeIn != 5'd0) & ~exl_q;
    assign IntReq     = int_pend | exc_pend;

    // A delay-slot instruction restarts at its branch, one word earlier.
    assign pc_aligned = PC & 32'hFFFF_FFFC;
    assign epc_exc    = BD ? (pc_aligned - 32'd4) : pc_aligned;

    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        ip_d      = HWInt;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        if (IntReq) begin
            // Taking the exception swallows any MTC0 sitting in M.
            exl_d     = 1'b1;
            bd_d      = BD;
            exccode_d = int_pend ? 5'd0 : ExcCodeIn;
            epc_d     = epc_exc;
        end else begin
            if (EXLClr) begin
                exl_d = 1'b0;
            end
            if (We) begin
                case (A2)
                    REG_SR: begin
                        im_d  = DIn[15:10];
                        exl_d = DIn[1];
                        ie_d  = DIn[0];
                    end
                    REG_EPC: epc_d = DIn;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q      <= '0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= '0;
            exccode_q <= '0;
            epc_q     <= '0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

    assign sr_word    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_word = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'd0};

    always_comb begin
        DOut = 32'd0;
        case (A1)
            REG_SR:    DOut = sr_word;
            REG_CAUSE: DOut = cause_word;
            REG_EPC:   DOut = epc_q;
            REG_PRID:  DOut = PRID_VALUE;
            default:   DOut = 32'd0;
        endcase
    end

    // Bypass so an ERET directly behind an MTC0 EPC sees the new address.
    assign EPCOut = (We && (A2 == REG_EPC)) ? DIn : epc_q;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios followed by random traffic,
// both compared against a word-level model of the CP0 registers.
module tb_cp0_unit;

    localparam logic [31:0] PRID = 32'h1900_0808;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2;
    logic [31:0] DIn;
    logic        We;
    logic [31:0] PC;
    logic        BD;
    logic [4:0]  ExcCodeIn;
    logic        EXLClr;
    logic [5:0]  HWInt;
    logic        IntReq;
    logic [31:0] EPCOut;
    logic [31:0] DOut;

    int errors = 0;
    int checks = 0;

    // Reference state kept as whole architectural register words.
    logic [31:0] m_sr, m_cause, m_epc;

    always #5 clk = ~clk;

    cp0_unit dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .We(We),
        .PC(PC), .BD(BD), .ExcCodeIn(ExcCodeIn), .EXLClr(EXLClr),
        .HWInt(HWInt), .IntReq(IntReq), .EPCOut(EPCOut), .DOut(DOut)
    );

    function automatic logic m_int_pend();
        return ((HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic m_intreq();
        return m_int_pend() || ((ExcCodeIn != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Settle inputs and compare the combinational outputs against the model.
    task automatic settle(input string tag);
        logic [31:0] exp_epcout;
        @(negedge clk);
        exp_epcout = (We && A2 == 5'd14) ? DIn : m_epc;
        check({tag, ".IntReq"}, {31'd0, IntReq}, {31'd0, m_intreq()});
        check({tag, ".EPCOut"}, EPCOut, exp_epcout);
        check({tag, ".DOut"}, DOut, m_read(A1));
        $display("cyc %s: A1=%0d DOut=%h IntReq=%b EPCOut=%h", tag, A1, DOut, IntReq, EPCOut);
    endtask

    // Clock edge: advance the model with the same inputs the DUT samples.
    task automatic advance();
        logic take, intp;
        @(posedge clk);
        take = m_intreq();
        intp = m_int_pend();
        if (reset) begin
            m_sr = 0; m_cause = 0; m_epc = 0;
        end else begin
            if (take) begin
                m_sr    = m_sr | 32'h2;
                m_cause = ({31'd0, BD} << 31) | ({27'd0, (intp ? 5'd0 : ExcCodeIn)} << 2);
                m_epc   = (PC & ~32'd3) - (BD ? 32'd4 : 32'd0);
            end else begin
                if (EXLClr) m_sr = m_sr & ~32'h2;
                if (We && A2 == 5'd12) m_sr = DIn & 32'h0000_FC03;
                if (We && A2 == 5'd14) m_epc = DIn;
            end
            m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, HWInt} << 10);
        end
        #1;
    endtask

    task automatic idle();
        reset = 0; We = 0; EXLClr = 0; HWInt = 0; ExcCodeIn = 0;
        BD = 0; PC = 32'h0000_3000; A2 = 5'd0; DIn = 0; A1 = 5'd0;
    endtask

    initial begin
        m_sr = 0; m_cause = 0; m_epc = 0;
        idle();
        reset = 1;
        @(posedge clk); #1;
        m_sr = 0; m_cause = 0; m_epc = 0;
        reset = 0;

        // Reset state readback
        for (int r = 12; r <= 15; r++) begin
            A1 = 5'(r);
            settle("reset_read");
            check("reset_read_const", DOut, (r == 15) ? PRID : 32'd0);
            advance();
        end

        // Enable IM[0]/IE, then raise HWInt[0]
        We = 1; A2 = 5'd12; DIn = 32'h0000_0401;
        settle("mtc0_sr"); advance();
        idle(); HWInt = 6'b000001; PC = 32'h0000_3010; A1 = 5'd12;
        settle("irq");
        check("irq_intreq", {31'd0, IntReq}, 32'd1);
        advance();
        idle(); A1 = 5'd14;
        settle("irq_epc");
        check("irq_epc_const", DOut, 32'h0000_3010);
        check("irq_intreq_low", {31'd0, IntReq}, 32'd0);
        advance();
        A1 = 5'd12; settle("irq_sr"); check("irq_sr_const", DOut, 32'h0000_0403); advance();
        EXLClr = 1; settle("eret1"); advance(); idle();

        // Synchronous exception in a delay slot
        ExcCodeIn = 5'd10; PC = 32'h0000_3024; BD = 1;
        settle("exc");
        check("exc_intreq", {31'd0, IntReq}, 32'd1);
        advance();
        idle(); A1 = 5'd14; settle("exc_epc"); check("exc_epc_const", DOut, 32'h0000_3020); advance();
        A1 = 5'd13; settle("exc_cause"); check("exc_cause_const", DOut, 32'h8000_0028); advance();
        EXLClr = 1; settle("eret2"); advance(); idle();

        // Interrupt beats exception; concurrent MTC0 EPC is dropped
        ExcCodeIn = 5'd12; HWInt = 6'b000001; PC = 32'h0000_5000;
        We = 1; A2 = 5'd14; DIn = 32'h1234_5678;
        settle("prio"); advance();
        idle(); A1 = 5'd14; settle("prio_epc"); check("prio_epc_const", DOut, 32'h0000_5000); advance();
        A1 = 5'd13; settle("prio_cause"); check("prio_exccode", {27'd0, DOut[6:2]}, 32'd0); advance();

        // MTC0 EPC alongside ERET: bypassed onto EPCOut
        We = 1; A2 = 5'd14; DIn = 32'h0000_4000; EXLClr = 1;
        settle("bypass"); check("bypass_epcout", EPCOut, 32'h0000_4000); advance();
        idle(); A1 = 5'd12; settle("bypass_sr"); check("bypass_exl_clear", DOut, 32'h0000_0401); advance();

        // PC=0 in a delay slot wraps
        ExcCodeIn = 5'd4; PC = 32'h0; BD = 1;
        settle("wrap"); advance();
        idle(); A1 = 5'd14; settle("wrap_epc"); check("wrap_epc_const", DOut, 32'hFFFF_FFFC); advance();
        EXLClr = 1; settle("eret3"); advance(); idle();

        // Reset on the same edge as IntReq
        HWInt = 6'b000001; PC = 32'h0000_7000; reset = 1;
        settle("rst_irq"); check("rst_irq_intreq", {31'd0, IntReq}, 32'd1); advance();
        idle(); A1 = 5'd14; settle("rst_epc"); check("rst_epc_const", DOut, 32'd0); advance();
        A1 = 5'd12; settle("rst_sr"); check("rst_sr_const", DOut, 32'd0); advance();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(0, 49) == 0);
            HWInt     = ($urandom_range(0, 2) == 0) ? 6'($urandom_range(0, 63)) : 6'd0;
            ExcCodeIn = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
            We        = ($urandom_range(0, 2) == 0);
            A2        = 5'($urandom_range(10, 16));
            DIn       = $urandom;
            PC        = $urandom;
            BD        = 1'($urandom_range(0, 1));
            A1        = 5'($urandom_range(10, 16));
            EXLClr    = ($urandom_range(0, 3) == 0) && !(We && A2 == 5'd12);
            settle("rand");
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
